// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single data-memory port: CPU MEM stage has priority,
// the external master gets a starvation-bounded grant and optional locked bursts.
// Optional statistics counters are enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int CW       = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic              ext_lock,
    input  logic [31:0]       ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_rvalid,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_a,
    output logic [DATA_W-1:0] dm_d,
    input  logic [DATA_W-1:0] dm_spo
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_cpu_stalls,
    output logic [31:0]       stat_ext_grants
`endif
);

    typedef enum logic [0:0] {
        ARB       = 1'b0,
        EXT_BURST = 1'b1
    } state_t;

    localparam logic [CW-1:0] MAX_WAIT_C = CW'(MAX_WAIT);

    state_t              state_reg, state_next;
    logic [CW-1:0]       wait_cnt_reg, wait_cnt_next;
    logic                ext_rvalid_reg;
    logic [DATA_W-1:0]   ext_rdata_reg;
    logic                cpu_gnt;
    logic                wait_full;

    assign wait_full = (wait_cnt_reg == MAX_WAIT_C);

    // Grant decision and next state; ext_gnt is computed first so the CPU grant can depend on it.
    always_comb begin
        ext_gnt    = 1'b0;
        cpu_gnt    = 1'b0;
        state_next = state_reg;
        case (state_reg)
            ARB: begin
                ext_gnt = ext_req & (~cpu_req | wait_full);
                cpu_gnt = cpu_req & ~ext_gnt;
                if (ext_gnt & ext_lock)
                    state_next = EXT_BURST;
            end
            EXT_BURST: begin
                ext_gnt = ext_req;
                if (~ext_lock | ~ext_req)
                    state_next = ARB;
            end
            default: state_next = ARB;
        endcase
    end

    // Wait counter only advances while ext is actually being held off.
    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (~ext_req | ext_gnt)
            wait_cnt_next = '0;
        else if (!wait_full)
            wait_cnt_next = wait_cnt_reg + 1'b1;
    end

    assign cpu_stall  = cpu_req & ~cpu_gnt;
    assign cpu_rdata  = dm_spo;
    assign dm_we      = (cpu_gnt & cpu_we) | (ext_gnt & ext_we);
    assign dm_a       = ext_gnt ? ext_addr[ADDR_W+1:2] : cpu_addr[ADDR_W+1:2];
    assign dm_d       = ext_gnt ? ext_wdata : cpu_wdata;
    assign ext_rvalid = ext_rvalid_reg;
    assign ext_rdata  = ext_rdata_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ARB;
            wait_cnt_reg   <= '0;
            ext_rvalid_reg <= 1'b0;
            ext_rdata_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            wait_cnt_reg   <= wait_cnt_next;
            ext_rvalid_reg <= ext_gnt & ~ext_we;
            if (ext_gnt & ~ext_we)
                ext_rdata_reg <= dm_spo;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_cpu_stalls_reg;
    logic [31:0] stat_ext_grants_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cpu_stalls_reg <= '0;
            stat_ext_grants_reg <= '0;
        end else begin
            if (cpu_stall)
                stat_cpu_stalls_reg <= stat_cpu_stalls_reg + 32'd1;
            if (ext_gnt)
                stat_ext_grants_reg <= stat_ext_grants_reg + 32'd1;
        end
    end

    assign stat_cpu_stalls = stat_cpu_stalls_reg;
    assign stat_ext_grants = stat_ext_grants_reg;
`endif

    // Byte-lane and high address bits are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                                ext_addr[31:ADDR_W+2], ext_addr[1:0]};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle vector table against a behavioural memory,
// plus a hand-written asynchronous reset in the middle of a locked burst.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        ext_req, ext_we, ext_lock;
    logic [31:0] ext_addr, ext_wdata, ext_rdata;
    logic        ext_gnt, ext_rvalid;
    logic        dm_we;
    logic [13:0] dm_a;
    logic [31:0] dm_d, dm_spo;

    logic [31:0] mem [0:16383];

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter #(.ADDR_W(14), .DATA_W(32), .MAX_WAIT(4), .CW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
        .dm_we(dm_we), .dm_a(dm_a), .dm_d(dm_d), .dm_spo(dm_spo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory: async read, sync write.
    assign dm_spo = mem[dm_a];
    always @(posedge clk) if (dm_we) mem[dm_a] <= dm_d;

    typedef struct {
        logic        cpu_req, cpu_we;
        logic [31:0] cpu_addr, cpu_wdata;
        logic        ext_req, ext_we, ext_lock;
        logic [31:0] ext_addr, ext_wdata;
        logic        e_stall, e_gnt, e_we;
        logic [13:0] e_a;
        logic        chk_crd;
        logic [31:0] e_crd;
        logic        e_rvalid, chk_erd;
        logic [31:0] e_erd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic creq, input logic cwe, input logic [31:0] caddr, input logic [31:0] cwd,
        input logic ereq, input logic ewe, input logic elock, input logic [31:0] eaddr,
        input logic [31:0] ewd, input logic xstall, input logic xgnt, input logic xwe,
        input logic [13:0] xa, input logic ccrd, input logic [31:0] xcrd,
        input logic xrv, input logic cerd, input logic [31:0] xerd);
        vec_t v;
        v.cpu_req = creq;  v.cpu_we = cwe;  v.cpu_addr = caddr;  v.cpu_wdata = cwd;
        v.ext_req = ereq;  v.ext_we = ewe;  v.ext_lock = elock;  v.ext_addr = eaddr;
        v.ext_wdata = ewd; v.e_stall = xstall; v.e_gnt = xgnt;  v.e_we = xwe;  v.e_a = xa;
        v.chk_crd = ccrd;  v.e_crd = xcrd;  v.e_rvalid = xrv;  v.chk_erd = cerd; v.e_erd = xerd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp, input int idx);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL row %0d %s: got %h expected %h", idx, nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        cpu_req = v.cpu_req;  cpu_we = v.cpu_we;  cpu_addr = v.cpu_addr;  cpu_wdata = v.cpu_wdata;
        ext_req = v.ext_req;  ext_we = v.ext_we;  ext_lock = v.ext_lock;  ext_addr = v.ext_addr;
        ext_wdata = v.ext_wdata;
    endtask

    task automatic check_row(input vec_t v, input int idx);
        chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, v.e_stall}, idx);
        chk("ext_gnt", {31'd0, ext_gnt}, {31'd0, v.e_gnt}, idx);
        chk("dm_we", {31'd0, dm_we}, {31'd0, v.e_we}, idx);
        chk("dm_a", {18'd0, dm_a}, {18'd0, v.e_a}, idx);
        chk("ext_rvalid", {31'd0, ext_rvalid}, {31'd0, v.e_rvalid}, idx);
        if (v.chk_crd) chk("cpu_rdata", cpu_rdata, v.e_crd, idx);
        if (v.chk_erd) chk("ext_rdata", ext_rdata, v.e_erd, idx);
        $display("row %0d: cpu_req=%0b ext_req=%0b lock=%0b -> stall=%0b gnt=%0b we=%0b a=%h rvalid=%0b",
                 idx, v.cpu_req, v.ext_req, v.ext_lock, cpu_stall, ext_gnt, dm_we, dm_a, ext_rvalid);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t h;
        for (int i = 0; i < 16384; i++) mem[i] = 32'd0;

        // Idle: row 0
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,0, 0,0,0,14'h0, 0,0, 0,0,0));
        // CPU alone: store then load 0x10
        vecs.push_back(mk(1,1,32'h10,32'hDEADBEEF, 0,0,0,0,0, 0,0,1,14'h4, 0,0, 0,0,0));
        vecs.push_back(mk(1,0,32'h10,0, 0,0,0,0,0, 0,0,0,14'h4, 1,32'hDEADBEEF, 0,0,0));
        // Ext alone: read 0x10, rvalid one cycle later, then clear
        vecs.push_back(mk(0,0,0,0, 1,0,0,32'h10,0, 0,1,0,14'h4, 0,0, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,0, 0,0,0,14'h0, 0,0, 1,1,32'hDEADBEEF));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,0, 0,0,0,14'h0, 0,0, 0,0,0));
        // Contention: CPU 4 cycles, forced ext grant, CPU again
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(1,0,0,0, 1,0,0,32'h10,0, 0,0,0,14'h0, 1,0, 0,0,0));
        vecs.push_back(mk(1,0,0,0, 1,0,0,32'h10,0, 1,1,0,14'h4, 0,0, 0,0,0));
        vecs.push_back(mk(1,0,0,0, 1,0,0,32'h10,0, 0,0,0,14'h0, 0,0, 1,1,32'hDEADBEEF));
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,0, 0,0,0,14'h0, 0,0, 0,0,0));
        // Burst: ext waits out the CPU, then holds the port for 3 writes
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(1,0,0,0, 1,1,1,32'h20,32'hA1A1A1A1, 0,0,0,14'h0, 0,0, 0,0,0));
        vecs.push_back(mk(1,0,0,0, 1,1,1,32'h20,32'hA1A1A1A1, 1,1,1,14'h8, 0,0, 0,0,0));
        vecs.push_back(mk(1,0,0,0, 1,1,1,32'h24,32'hA2A2A2A2, 1,1,1,14'h9, 0,0, 0,0,0));
        vecs.push_back(mk(1,0,0,0, 1,1,0,32'h28,32'hA3A3A3A3, 1,1,1,14'hA, 0,0, 0,0,0));
        vecs.push_back(mk(1,0,32'h20,0, 0,0,0,0,0, 0,0,0,14'h8, 1,32'hA1A1A1A1, 0,0,0));
        vecs.push_back(mk(1,0,32'h24,0, 0,0,0,0,0, 0,0,0,14'h9, 1,32'hA2A2A2A2, 0,0,0));
        vecs.push_back(mk(1,0,32'h28,0, 0,0,0,0,0, 0,0,0,14'hA, 1,32'hA3A3A3A3, 0,0,0));
        // Stalled CPU store must not write; it lands on the following granted cycle
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(1,0,0,0, 1,0,0,32'h10,0, 0,0,0,14'h0, 0,0, 0,0,0));
        vecs.push_back(mk(1,1,32'h30,32'h11111111, 1,0,0,32'h10,0, 1,1,0,14'h4, 0,0, 0,0,0));
        vecs.push_back(mk(1,1,32'h30,32'h11111111, 0,0,0,0,0, 0,0,1,14'hC, 1,32'h0, 1,1,32'hDEADBEEF));
        vecs.push_back(mk(1,0,32'h30,0, 0,0,0,0,0, 0,0,0,14'hC, 1,32'h11111111, 0,0,0));

        // Reset state
        rst_n = 1'b0;
        drive(mk(0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0, 0,0,0));
        repeat (2) @(negedge clk);
        #2;
        chk("rst ext_rvalid", {31'd0, ext_rvalid}, 32'd0, -1);
        chk("rst ext_rdata", ext_rdata, 32'd0, -1);
        chk("rst cpu_stall", {31'd0, cpu_stall}, 32'd0, -1);
        chk("rst ext_gnt", {31'd0, ext_gnt}, 32'd0, -1);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            check_row(vecs[i], i);
        end

        // Enter a locked burst with an ext write, then issue a locked ext read
        h = mk(0,0,0,0, 1,1,1,32'h50,32'h55555555, 0,1,1,14'h14, 0,0, 0,0,0);
        @(negedge clk); drive(h); #2; check_row(h, 100);
        h = mk(1,0,0,0, 1,0,1,32'h10,0, 1,1,0,14'h4, 0,0, 0,0,0);
        @(negedge clk); drive(h); #2; check_row(h, 101);
        @(negedge clk); drive(h); #2;
        chk("burst ext_rvalid", {31'd0, ext_rvalid}, 32'd1, 102);
        chk("burst ext_rdata", ext_rdata, 32'hDEADBEEF, 102);
        chk("burst cpu_stall", {31'd0, cpu_stall}, 32'd1, 102);
        // Asynchronous reset mid-cycle: lock dropped, CPU wins immediately
        rst_n = 1'b0;
        #1;
        chk("midrst ext_rvalid", {31'd0, ext_rvalid}, 32'd0, 103);
        chk("midrst ext_rdata", ext_rdata, 32'd0, 103);
        chk("midrst cpu_stall", {31'd0, cpu_stall}, 32'd0, 103);
        chk("midrst ext_gnt", {31'd0, ext_gnt}, 32'd0, 103);
        chk("midrst dm_a", {18'd0, dm_a}, 32'd0, 103);
        $display("row 103: async reset mid-burst -> stall=%0b gnt=%0b rvalid=%0b", cpu_stall, ext_gnt, ext_rvalid);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("postrst cpu_stall", {31'd0, cpu_stall}, 32'd0, 104);
        @(negedge clk); #2;
        chk("postrst2 cpu_stall", {31'd0, cpu_stall}, 32'd0, 105);
        chk("postrst2 ext_gnt", {31'd0, ext_gnt}, 32'd0, 105);
        $display("row 105: after reset release -> stall=%0b gnt=%0b", cpu_stall, ext_gnt);

        drive(mk(0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0, 0,0,0));
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
